// File: rtl/upload_rr_switcher.sv
`default_nettype none
// ============================================================================
// upload_rr_switcher
// N-channel round-robin upload switcher feeding the host upload FIFO.
// Optional header beat on each upload start: define HEADER_EN.
// Revision: 1.0
// ============================================================================
module upload_rr_switcher #(
    parameter int NUM_CH         = 4,
    parameter int DATA_W         = 64,
    parameter int PERIOD         = 4096,
    parameter int START_OFFSET   = 2048,
    parameter int WARMUP_PERIODS = 3,
    localparam int CH_W          = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     upload_en,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        data_valid_i,
    output logic [NUM_CH-1:0]        upload_start_o,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid_o,
    output logic [CH_W-1:0]          ch_id_o,
    output logic [15:0]              frame_cnt_o
);

    localparam logic [15:0] C_CNT_LAST = 16'(PERIOD - 1);
    localparam logic [15:0] C_START_AT = 16'(START_OFFSET);
    localparam logic [15:0] C_WARMUP   = 16'(WARMUP_PERIODS);

    logic [15:0]       cnt;
    logic [15:0]       rb_cnt;
    logic [CH_W-1:0]   sel_ahd;
    logic [CH_W-1:0]   sel;
    logic              switch_pulse;
    logic              start_pulse;

    logic [CH_W-1:0]   rr_next;
    logic [DATA_W-1:0] mux_data;
    logic              mux_valid;
    logic [NUM_CH-1:0] start_vec;

    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    // Scan from farthest to nearest so the nearest enabled channel is the last
    // assignment; offset NUM_CH is the current channel itself.
    always_comb begin
        rr_next = sel_ahd;
        for (int j = NUM_CH; j >= 1; j--) begin
            if (ch_mask[wrap_idx(sel_ahd, j)]) rr_next = wrap_idx(sel_ahd, j);
        end
    end

    always_comb begin
        mux_data  = '0;
        mux_valid = 1'b0;
        start_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == CH_W'(i)) begin
                mux_data     = data_in[i*DATA_W +: DATA_W];
                mux_valid    = data_valid_i[i];
                start_vec[i] = start_pulse & ch_mask[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= C_CNT_LAST;
            rb_cnt         <= '0;
            sel_ahd        <= '0;
            sel            <= '0;
            switch_pulse   <= 1'b0;
            start_pulse    <= 1'b0;
            upload_start_o <= '0;
            data_out       <= '0;
            data_valid_o   <= 1'b0;
            ch_id_o        <= '0;
            frame_cnt_o    <= '0;
        end else begin
            sel          <= sel_ahd;
            ch_id_o      <= sel;
            data_out     <= mux_data;
            data_valid_o <= mux_valid;
            if (!upload_en) begin
                cnt            <= C_CNT_LAST;
                rb_cnt         <= '0;
                sel_ahd        <= '0;
                switch_pulse   <= 1'b0;
                start_pulse    <= 1'b0;
                upload_start_o <= '0;
            end else begin
                cnt            <= (cnt == C_CNT_LAST) ? 16'd0 : cnt + 16'd1;
                switch_pulse   <= (cnt == 16'd1);
                start_pulse    <= (cnt == C_START_AT);
                upload_start_o <= start_vec;
                if (|start_vec) begin
                    frame_cnt_o <= frame_cnt_o + 16'd1;
`ifdef HEADER_EN
                    // Header carries the frame count before this start's increment
                    data_out     <= DATA_W'({16'hA55A, 16'(sel), frame_cnt_o});
                    data_valid_o <= 1'b1;
`endif
                end
                if (switch_pulse) begin
                    if (rb_cnt != 16'hFFFF) rb_cnt <= rb_cnt + 16'd1;
                    sel_ahd <= (rb_cnt < C_WARMUP) ? '0 : rr_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_upload_rr_switcher.sv
`default_nettype none
// ============================================================================
// tb_upload_rr_switcher
// Randomized bench for upload_rr_switcher against a slot-level reference model.
// Revision: 1.0
// ============================================================================
module tb_upload_rr_switcher;

    localparam int NUM_CH         = 4;
    localparam int DATA_W         = 64;
    localparam int PERIOD         = 64;
    localparam int START_OFFSET   = 32;
    localparam int WARMUP_PERIODS = 3;
    localparam int CH_W           = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     upload_en;
    logic [NUM_CH-1:0]        ch_mask;
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic [NUM_CH-1:0]        data_valid_i;
    logic [NUM_CH-1:0]        upload_start_o;
    logic [DATA_W-1:0]        data_out;
    logic                     data_valid_o;
    logic [CH_W-1:0]          ch_id_o;
    logic [15:0]              frame_cnt_o;

    upload_rr_switcher #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PERIOD(PERIOD),
        .START_OFFSET(START_OFFSET), .WARMUP_PERIODS(WARMUP_PERIODS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .upload_en(upload_en), .ch_mask(ch_mask),
        .data_in(data_in), .data_valid_i(data_valid_i),
        .upload_start_o(upload_start_o), .data_out(data_out),
        .data_valid_o(data_valid_o), .ch_id_o(ch_id_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int start_log[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time since enable is split into slots of PERIOD clocks;
    // each slot's channel is decided early in the slot, the start fires at a fixed phase.
    int                m_age;
    int                m_choice;
    int                m_active;
    int                m_prev;
    logic [15:0]       m_frame;
    logic [NUM_CH-1:0] exp_start;
    logic [DATA_W-1:0] exp_data;
    logic              exp_valid;
    logic [CH_W-1:0]   exp_id;

    function automatic int pick(input int slot, input int cur, input logic [NUM_CH-1:0] mask);
        if (slot < WARMUP_PERIODS) return 0;
        for (int j = 1; j <= NUM_CH; j++) begin
            if (mask[(cur + j) % NUM_CH]) return (cur + j) % NUM_CH;
        end
        return cur;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age = -1; m_choice = 0; m_active = 0; m_frame = '0;
            exp_start = '0; exp_data = '0; exp_valid = 1'b0; exp_id = '0;
        end else begin
            m_prev    = m_active;
            m_active  = m_choice;
            exp_data  = data_in[m_prev*DATA_W +: DATA_W];
            exp_valid = data_valid_i[m_prev];
            exp_id    = CH_W'(m_prev);
            exp_start = '0;
            if (!upload_en) begin
                m_age = -1;
                m_choice = 0;
            end else begin
                m_age++;
                if (m_age % PERIOD == 3) m_choice = pick(m_age / PERIOD, m_choice, ch_mask);
                if ((m_age % PERIOD == START_OFFSET + 2) && ch_mask[m_prev]) begin
                    exp_start[m_prev] = 1'b1;
`ifdef HEADER_EN
                    exp_data  = {16'h0, 16'hA55A, 16'(m_prev), m_frame};
                    exp_valid = 1'b1;
`endif
                    m_frame++;
                end
            end
        end
    end

    task automatic compare_outputs();
        check_eq("upload_start", 64'(upload_start_o), 64'(exp_start));
        check_eq("data_out", data_out, exp_data);
        check_eq("data_valid", 64'(data_valid_o), 64'(exp_valid));
        check_eq("ch_id", 64'(ch_id_o), 64'(exp_id));
        check_eq("frame_cnt", 64'(frame_cnt_o), 64'(m_frame));
    endtask

    task automatic step();
        @(negedge clk);
        compare_outputs();
        for (int i = 0; i < NUM_CH; i++) if (upload_start_o[i]) start_log.push_back(i);
        for (int i = 0; i < NUM_CH; i++) data_in[i*DATA_W +: DATA_W] = {$urandom, $urandom};
        data_valid_i = NUM_CH'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_seq(input string tag, input int want[$]);
        check_eq({tag, "_count"}, 64'(start_log.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < start_log.size(); i++)
            check_eq({tag, "_ch"}, 64'(start_log[i]), 64'(want[i]));
    endtask

    int seq_full[$] = '{0, 0, 0, 1, 2, 3, 0};
    int seq_odd[$]  = '{1, 3, 1, 3};
    int off_cnt;

    initial begin
        rst_n = 1'b0; upload_en = 1'b0; ch_mask = 4'hF;
        data_in = '0; data_valid_i = '0;
        run(3);
        rst_n = 1'b1;
        run(2);

        // All channels enabled: warmup on ch0, then rotate
        start_log.delete();
        upload_en = 1'b1;
        run(7 * PERIOD);
        check_seq("s1", seq_full);
        check_eq("s1_frame", 64'(frame_cnt_o), 64'd7);

        // Channel 0 masked: warmup slots issue nothing
        upload_en = 1'b0;
        run(3);
        ch_mask = 4'b1010;
        start_log.delete();
        upload_en = 1'b1;
        run(7 * PERIOD);
        check_seq("s2", seq_odd);
        check_eq("s2_frame", 64'(frame_cnt_o), 64'd11);

        // Enable dropped at cnt=20: aborted slot, fresh warmup, count preserved
        upload_en = 1'b0;
        run(2);
        ch_mask = 4'hF;
        start_log.delete();
        upload_en = 1'b1;
        run(21);
        upload_en = 1'b0;
        run(5);
        upload_en = 1'b1;
        run(7 * PERIOD);
        check_seq("s4", seq_full);
        check_eq("s4_frame", 64'(frame_cnt_o), 64'd18);

        // Asynchronous reset mid-slot
        run(100);
        rst_n = 1'b0;
        #1;
        compare_outputs();
        check_eq("async_rst_frame", 64'(frame_cnt_o), 64'd0);
        step();
        rst_n = 1'b1;
        start_log.delete();
        run(7 * PERIOD);
        check_seq("s5", seq_full);
        check_eq("s5_frame", 64'(frame_cnt_o), 64'd7);

        // Random masks and enable drops
        off_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) ch_mask = NUM_CH'($urandom);
            if (off_cnt > 0) begin
                off_cnt--;
                if (off_cnt == 0) upload_en = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                upload_en = 1'b0;
                off_cnt = int'($urandom_range(1, 8));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
